seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for the 4-digit, common-anode, active-low seven-segment display.
- Accepts four hex nibbles, per-digit decimal-point and blank masks, and a blink enable.
- Scans one digit per refresh slot and produces the an/seg/dp bus plus the blink level, which feed the display flash stage ahead of the board pins.
- Digit updates are double-buffered and applied only at frame boundaries, so no frame ever shows a mix of old and new values.

Parameters:
- REFRESH_DIV, 100000: clock cycles each digit stays lit (≥2).
- BLINK_DIV, 25000000: enabled clock cycles per blink half-period (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- digits  input  16  hex values; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- dp_mask  input  4  1 = decimal point lit on that digit.
- blank_mask  input  4  1 = digit dark (anode held off).
- update  input  1  one-cycle strobe; captures digits/dp_mask/blank_mask into the shadow registers.
- blink_en  input  1  1 = blink generator runs.
- an  output  4  anodes, active-low, one-hot-zero.
- seg  output  7  {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- blink  output  1  1 = display visible, 0 = dark phase.
- update_pending  output  1  shadow holds values not yet applied.

Behaviour:
- Reset (synchronous, any cycle, including mid-frame or mid-blink):
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1, blink=1, update_pending=0.
  - State: refresh counter=0, digit index=0, blink counter=0.
  - Active and shadow registers cleared (digits=0, masks=0).
- Refresh counter counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it returns to 0 and the index advances 0→1→2→3→0. The 3→0 advance is the frame wrap.
- Outputs are registered functions of (index, active registers), with one cycle of lag:
  - Each an pattern is held exactly REFRESH_DIV cycles; frame period = 4·REFRESH_DIV.
  - The first cycle after reset deasserts shows an=4'b1110, seg=7'b1000000, dp=1.
- Anode: an[i]=0 when index=i, all other bits 1. If blank_mask_active[i]=1, an=4'b1111 and seg=7'b1111111 for that slot.
- dp = ~dp_mask_active[index].
- Hex decode (seg value):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Update handshake:
  - update=1 loads the shadow registers and sets update_pending=1.
  - At a frame wrap with update_pending=1, shadow→active and update_pending→0.
  - Multiple updates before a wrap: the last one wins.
  - update on the same cycle as a wrap: new input values go directly to active, shadow is loaded too, update_pending stays 0.
  - The new values first appear on outputs in the digit-0 slot following the wrap.
- Blink:
  - blink_en=0: counter held at 0; blink forced to 1 on the next edge.
  - blink_en=1: counter counts 0..BLINK_DIV-1; at BLINK_DIV-1 blink toggles and the counter returns to 0. The first toggle (1→0) occurs on the BLINK_DIV-th enabled edge.
  - Re-enabling always restarts from blink=1 with the counter at 0.
- blink does not gate an/seg/dp inside this block; gating is done downstream.
- All counters wrap modulo their parameter, with no overflow states. Counter widths are $clog2 of the corresponding parameter.

Test Plan (REFRESH_DIV=4, BLINK_DIV=8):
- Reset: assert reset 3 cycles mid-scan → an=1111, seg=1111111, dp=1, blink=1, update_pending=0. Release → next edge an=1110, seg=1000000.
- Scan: update digits=16'h3A71 with masks 0 at reset release. After wrap, the frame shows:
  - an=1110 seg=1111001 for 4 cycles
  - an=1101 seg=1111000
  - an=1011 seg=0001000
  - an=0111 seg=0110000
  - period 16 cycles.
- Tear-free: with 16'h3A71 shown, update 16'hFFFF during the digit-1 slot → update_pending=1; digits 2,3 still show A,3; the next digit-0 slot shows 0001110 and update_pending=0.
- Coincident: update 16'h0008 on the wrap cycle → next digit-0 slot shows 0000000, update_pending never goes high.
- Masks: update dp_mask=0101, blank_mask=1000 → dp=0 in slots 0 and 2, dp=1 in slot 1, an=1111 and seg=1111111 throughout slot 3.
- Blink: raise blink_en → blink=0 after 8 cycles, back to 1 after 16 (period 16). Drop blink_en while blink=0 → blink=1 next edge. Re-raise → first toggle 8 cycles later.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver (common anode, active-low) with
// frame-synchronous double-buffered updates and a free-running blink level.
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_mask,
    input  logic [3:0]  blank_mask,
    input  logic        update,
    input  logic        blink_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        blink,
    output logic        update_pending
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [RW-1:0] r_ref_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;

    logic [15:0]   r_sh_digits;
    logic [3:0]    r_sh_dp;
    logic [3:0]    r_sh_blank;
    logic [15:0]   r_act_digits;
    logic [3:0]    r_act_dp;
    logic [3:0]    r_act_blank;
    logic          r_pending;

    logic [3:0]    r_an_p1;
    logic [6:0]    r_seg_p1;
    logic          r_dp_p1;

    logic          w_slot_end;
    logic          w_frame_wrap;
    logic [3:0]    w_nib;
    logic [3:0]    w_an_next;
    logic [6:0]    w_seg_next;
    logic          w_dp_next;

    assign w_slot_end   = (r_ref_cnt == REF_LAST);
    assign w_frame_wrap = w_slot_end && (r_idx == 2'd3);

    // Refresh timebase and digit index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ref_cnt <= '0;
            r_idx     <= 2'd0;
        end else if (w_slot_end) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
        end else begin
            r_ref_cnt <= r_ref_cnt + RW'(1);
        end
    end

    // Shadow/active buffers: active only changes on the frame wrap, and an
    // update landing on the wrap itself bypasses the shadow so nothing is lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_digits  <= '0;
            r_sh_dp      <= '0;
            r_sh_blank   <= '0;
            r_act_digits <= '0;
            r_act_dp     <= '0;
            r_act_blank  <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (update) begin
                r_sh_digits <= digits;
                r_sh_dp     <= dp_mask;
                r_sh_blank  <= blank_mask;
            end
            if (w_frame_wrap && update) begin
                r_act_digits <= digits;
                r_act_dp     <= dp_mask;
                r_act_blank  <= blank_mask;
                r_pending    <= 1'b0;
            end else if (w_frame_wrap && r_pending) begin
                r_act_digits <= r_sh_digits;
                r_act_dp     <= r_sh_dp;
                r_act_blank  <= r_sh_blank;
                r_pending    <= 1'b0;
            end else if (update) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign w_nib = r_act_digits[{r_idx, 2'b00} +: 4];

    always_comb begin
        w_an_next  = ~(4'b0001 << r_idx);
        w_seg_next = hex7(w_nib);
        w_dp_next  = ~r_act_dp[r_idx];
        if (r_act_blank[r_idx]) begin
            w_an_next  = 4'b1111;
            w_seg_next = 7'b1111111;
        end
    end

    // Output register stage: one cycle behind the index
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an_p1  <= 4'b1111;
            r_seg_p1 <= 7'b1111111;
            r_dp_p1  <= 1'b1;
        end else begin
            r_an_p1  <= w_an_next;
            r_seg_p1 <= w_seg_next;
            r_dp_p1  <= w_dp_next;
        end
    end

    // Blink generator; disabling parks it in the visible phase
    always_ff @(posedge clk) begin
        if (reset || !blink_en) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b1;
        end else if (r_blink_cnt == BLK_LAST) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + BW'(1);
        end
    end

    assign an             = r_an_p1;
    assign seg            = r_seg_p1;
    assign dp             = r_dp_p1;
    assign blink          = r_blink;
    assign update_pending = r_pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4, BLINK_DIV=8.
module tb_seg7_scan_driver;

    localparam int RD = 4;
    localparam int BD = 8;

    localparam logic [3:0] AN_TAB   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    localparam logic [6:0] SCAN_SEG [4] = '{7'b1111001, 7'b1111000, 7'b0001000, 7'b0110000};
    localparam logic [11:0] MASK_EXP [4] = '{{4'b1110, 7'b0000000, 1'b0},
                                             {4'b1101, 7'b1000000, 1'b1},
                                             {4'b1011, 7'b1000000, 1'b0},
                                             {4'b1111, 7'b1111111, 1'b1}};

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
    logic        update;
    logic        blink_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        blink;
    logic        update_pending;

    int n_checks = 0;
    int n_fail   = 0;
    int k        = 0;

    seg7_scan_driver #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset(reset), .digits(digits), .dp_mask(dp_mask),
        .blank_mask(blank_mask), .update(update), .blink_en(blink_en),
        .an(an), .seg(seg), .dp(dp), .blink(blink), .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; digits = '0; dp_mask = '0; blank_mask = '0;
        update = 1'b0; blink_en = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({an, seg, dp, blink, update_pending} !== {4'b1111, 7'b1111111, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL reset_init got %b required %b", {an, seg, dp, blink, update_pending},
                     {4'b1111, 7'b1111111, 1'b1, 1'b1, 1'b0});
            n_fail++;
        end
        reset = 1'b0; k = 0;
        tick();
        n_checks++;
        if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
            $display("FAIL first_after_reset got %b required %b", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
            n_fail++;
        end
        blink_en = 1'b1;
        repeat (9) tick();
        n_checks++;
        if ({an, blink} !== {4'b1011, 1'b0}) begin
            $display("FAIL pre_reset_state got %b required %b", {an, blink}, {4'b1011, 1'b0});
            n_fail++;
        end
        reset = 1'b1; update = 1'b1; digits = 16'h3A71;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if ({an, seg, dp, blink, update_pending} !== {4'b1111, 7'b1111111, 1'b1, 1'b1, 1'b0}) begin
                $display("FAIL reset_mid cyc=%0d got %b required %b", i, {an, seg, dp, blink, update_pending},
                         {4'b1111, 7'b1111111, 1'b1, 1'b1, 1'b0});
                n_fail++;
            end
        end
        reset = 1'b0; blink_en = 1'b0; k = 0;
        tick();
        update = 1'b0;
        n_checks++;
        if ({an, seg, dp, blink, update_pending} !== {4'b1110, 7'b1000000, 1'b1, 1'b1, 1'b1}) begin
            $display("FAIL release got %b required %b", {an, seg, dp, blink, update_pending},
                     {4'b1110, 7'b1000000, 1'b1, 1'b1, 1'b1});
            n_fail++;
        end
    endtask

    task automatic test_scan();
        run_to(15);
        n_checks++;
        if (update_pending !== 1'b1) begin
            $display("FAIL scan_pending_before_wrap got %b required 1", update_pending);
            n_fail++;
        end
        run_to(16);
        n_checks++;
        if (update_pending !== 1'b0) begin
            $display("FAIL scan_pending_after_wrap got %b required 0", update_pending);
            n_fail++;
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            n_checks++;
            if ({an, seg} !== {AN_TAB[c/4], SCAN_SEG[c/4]}) begin
                $display("FAIL scan_frame k=%0d got %b required %b", k, {an, seg}, {AN_TAB[c/4], SCAN_SEG[c/4]});
                n_fail++;
            end
        end
        tick();
        n_checks++;
        if ({an, seg} !== {4'b1110, 7'b1111001}) begin
            $display("FAIL scan_period got %b required %b", {an, seg}, {4'b1110, 7'b1111001});
            n_fail++;
        end
    endtask

    task automatic test_tear_free();
        run_to(37);
        digits = 16'hFFFF; update = 1'b1;
        tick();
        update = 1'b0;
        n_checks++;
        if ({an, seg, update_pending} !== {4'b1101, 7'b1111000, 1'b1}) begin
            $display("FAIL tear_slot1 got %b required %b", {an, seg, update_pending}, {4'b1101, 7'b1111000, 1'b1});
            n_fail++;
        end
        run_to(41);
        n_checks++;
        if ({an, seg} !== {4'b1011, 7'b0001000}) begin
            $display("FAIL tear_slot2 got %b required %b", {an, seg}, {4'b1011, 7'b0001000});
            n_fail++;
        end
        run_to(47);
        n_checks++;
        if ({an, seg, update_pending} !== {4'b0111, 7'b0110000, 1'b1}) begin
            $display("FAIL tear_slot3 got %b required %b", {an, seg, update_pending}, {4'b0111, 7'b0110000, 1'b1});
            n_fail++;
        end
        run_to(49);
        n_checks++;
        if ({an, seg, update_pending} !== {4'b1110, 7'b0001110, 1'b0}) begin
            $display("FAIL tear_new_frame got %b required %b", {an, seg, update_pending}, {4'b1110, 7'b0001110, 1'b0});
            n_fail++;
        end
    endtask

    task automatic test_coincident();
        run_to(63);
        digits = 16'h0008; update = 1'b1;
        tick();
        update = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (update_pending !== 1'b0) begin
                $display("FAIL coinc_pending k=%0d got %b required 0", k, update_pending);
                n_fail++;
            end
            if (c == 0) begin
                tick();
                n_checks++;
                if ({an, seg} !== {4'b1110, 7'b0000000}) begin
                    $display("FAIL coinc_slot0 got %b required %b", {an, seg}, {4'b1110, 7'b0000000});
                    n_fail++;
                end
            end else begin
                tick();
            end
        end
        n_checks++;
        if ({an, seg} !== {4'b1101, 7'b1000000}) begin
            $display("FAIL coinc_slot1 got %b required %b", {an, seg}, {4'b1101, 7'b1000000});
            n_fail++;
        end
    endtask

    task automatic test_masks();
        digits = 16'h0008; dp_mask = 4'b0101; blank_mask = 4'b1000; update = 1'b1;
        tick();
        update = 1'b0;
        n_checks++;
        if (update_pending !== 1'b1) begin
            $display("FAIL mask_pending got %b required 1", update_pending);
            n_fail++;
        end
        run_to(80);
        for (int c = 0; c < 16; c++) begin
            tick();
            n_checks++;
            if ({an, seg, dp} !== MASK_EXP[c/4]) begin
                $display("FAIL mask_frame k=%0d got %b required %b", k, {an, seg, dp}, MASK_EXP[c/4]);
                n_fail++;
            end
        end
    endtask

    task automatic test_back_to_back();
        dp_mask = '0; blank_mask = '0;
        digits = 16'h1234; update = 1'b1;
        tick();
        digits = 16'h5678;
        tick();
        update = 1'b0;
        n_checks++;
        if (update_pending !== 1'b1) begin
            $display("FAIL b2b_pending got %b required 1", update_pending);
            n_fail++;
        end
        run_to(113);
        n_checks++;
        if ({an, seg, dp, update_pending} !== {4'b1110, 7'b0000000, 1'b1, 1'b0}) begin
            $display("FAIL b2b_slot0 got %b required %b", {an, seg, dp, update_pending}, {4'b1110, 7'b0000000, 1'b1, 1'b0});
            n_fail++;
        end
        run_to(117);
        n_checks++;
        if ({an, seg} !== {4'b1101, 7'b1111000}) begin
            $display("FAIL b2b_slot1 got %b required %b", {an, seg}, {4'b1101, 7'b1111000});
            n_fail++;
        end
        run_to(121);
        n_checks++;
        if ({an, seg} !== {4'b1011, 7'b0000010}) begin
            $display("FAIL b2b_slot2 got %b required %b", {an, seg}, {4'b1011, 7'b0000010});
            n_fail++;
        end
        run_to(125);
        n_checks++;
        if ({an, seg} !== {4'b0111, 7'b0010010}) begin
            $display("FAIL b2b_slot3 got %b required %b", {an, seg}, {4'b0111, 7'b0010010});
            n_fail++;
        end
    endtask

    task automatic test_blink();
        logic exp;
        blink_en = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            tick();
            exp = (i < 8) ? 1'b1 : (i < 16) ? 1'b0 : (i < 24) ? 1'b1 : 1'b0;
            n_checks++;
            if (blink !== exp) begin
                $display("FAIL blink_run edge=%0d got %b required %b", i, blink, exp);
                n_fail++;
            end
        end
        blink_en = 1'b0;
        tick();
        n_checks++;
        if (blink !== 1'b1) begin
            $display("FAIL blink_disable got %b required 1", blink);
            n_fail++;
        end
        blink_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = (i < 8) ? 1'b1 : 1'b0;
            n_checks++;
            if (blink !== exp) begin
                $display("FAIL blink_restart edge=%0d got %b required %b", i, blink, exp);
                n_fail++;
            end
        end
        blink_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tear_free();
        test_coincident();
        test_masks();
        test_back_to_back();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
